rv_fifo_endpoint: RTL and testbench



---
 rtl/rv_fifo_endpoint.sv | 78 +++++++
 tb/tb_rv_fifo_endpoint.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rv_fifo_endpoint.sv
// Ready/valid FIFO endpoint for one AXI-lite bridge user port: writes push words, reads pop them in order.
// NONBLOCK=1 keeps both channels always ready/valid and flags overflow/underflow on werror_o/rerror_o.
module rv_fifo_endpoint #(
  parameter int DW       = 32,
  parameter int DEPTH    = 16,
  parameter bit NONBLOCK = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wv_i,
  output logic                       wr_o,
  input  logic [DW-1:0]              wd_i,
  output logic                       werror_o,
  output logic                       rv_o,
  input  logic                       rr_i,
  output logic [DW-1:0]              rd_o,
  output logic                       rerror_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_pop_ok;
  logic w_push_ok;

  assign w_full  = (r_count == CNT_FULL);
  assign w_empty = (r_count == '0);

  // Ready/valid depend only on registered occupancy, never on wv_i/rr_i.
  assign wr_o = NONBLOCK ? 1'b1 : ~w_full;
  assign rv_o = NONBLOCK ? 1'b1 : ~w_empty;

  assign w_push    = wv_i & wr_o;
  assign w_pop     = rv_o & rr_i;
  assign w_pop_ok  = w_pop & ~w_empty;
  // A push into a full FIFO survives only if the same edge frees a slot.
  assign w_push_ok = w_push & (~w_full | w_pop_ok);

  assign werror_o = NONBLOCK & w_push & w_full & ~w_pop_ok;
  assign rerror_o = NONBLOCK & w_pop & w_empty;

  assign rd_o    = (NONBLOCK && w_empty) ? '0 : r_mem[r_rptr];
  assign level_o = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop_ok)  r_rptr <= r_rptr + PTR_ONE;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; a full-FIFO push+pop writes the slot being read, which is safe with a registered write.
  always_ff @(posedge clk) begin
    if (!rst && w_push_ok) r_mem[r_wptr] <= wd_i;
  end

endmodule

// File: tb/tb_rv_fifo_endpoint.sv
// Bench for rv_fifo_endpoint: one blocking and one non-blocking instance, both DEPTH=4, driven with identical stimulus.
// Directed table, hand-written corner sequences, then random traffic against queue-based models.
module tb_rv_fifo_endpoint;

  logic        clk = 1'b0;
  logic        rst;
  logic        wv;
  logic [31:0] wd;
  logic        rr;

  logic        wr0, rv0, werr0, rerr0;
  logic [31:0] rd0;
  logic [2:0]  lvl0;
  logic        wr1, rv1, werr1, rerr1;
  logic [31:0] rd1;
  logic [2:0]  lvl1;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];

  always #5 clk = ~clk;

  rv_fifo_endpoint #(.DW(32), .DEPTH(4), .NONBLOCK(1'b0)) u_blk (
    .clk(clk), .rst(rst), .wv_i(wv), .wr_o(wr0), .wd_i(wd), .werror_o(werr0),
    .rv_o(rv0), .rr_i(rr), .rd_o(rd0), .rerror_o(rerr0), .level_o(lvl0)
  );

  rv_fifo_endpoint #(.DW(32), .DEPTH(4), .NONBLOCK(1'b1)) u_nb (
    .clk(clk), .rst(rst), .wv_i(wv), .wr_o(wr1), .wd_i(wd), .werror_o(werr1),
    .rv_o(rv1), .rr_i(rr), .rd_o(rd1), .rerror_o(rerr1), .level_o(lvl1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs shortly after an edge and compare every output against the queue models.
  task automatic drive(input logic r, input logic w, input logic [31:0] d, input logic rd_rdy);
    int s0, s1;
    rst = r; wv = w; wd = d; rr = rd_rdy;
    #1;
    s0 = q0.size();
    s1 = q1.size();
    chk("blk_level", 32'(lvl0), 32'(s0));
    chk("blk_wready", 32'(wr0), 32'(s0 < 4));
    chk("blk_rvalid", 32'(rv0), 32'(s0 > 0));
    if (s0 > 0) chk("blk_rdata", rd0, q0[0]);
    chk("blk_errors", {30'd0, werr0, rerr0}, 32'd0);
    chk("nb_level", 32'(lvl1), 32'(s1));
    chk("nb_ready_valid", {30'd0, wr1, rv1}, 32'd3);
    chk("nb_rdata", rd1, (s1 > 0) ? q1[0] : 32'd0);
    if (!r) begin
      chk("nb_werror", 32'(werr1), 32'(w && s1 == 4 && !rd_rdy));
      chk("nb_rerror", 32'(rerr1), 32'(rd_rdy && s1 == 0));
    end
  endtask

  task automatic advance();
    bit pop0, push0, pop1, push1;
    pop0  = rr && q0.size() > 0;
    push0 = wv && q0.size() < 4;
    pop1  = rr && q1.size() > 0;
    push1 = wv && (q1.size() < 4 || pop1);
    @(posedge clk);
    if (rst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (pop0)  void'(q0.pop_front());
      if (push0) q0.push_back(wd);
      if (pop1)  void'(q1.pop_front());
      if (push1) q1.push_back(wd);
    end
    #1;
  endtask

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] d;
    logic        rd_rdy;
    int          l0;
    logic        wr0;
    logic        rv0;
    logic [31:0] rd0;
    int          l1;
    logic        we1;
    logic        re1;
    logic [31:0] rd1;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // Reset, push three words, drain.
    tbl.push_back(vec_t'{0,1,32'hdeadbeef,0, 0,1,0,32'h0,        0,0,0,32'h0});
    tbl.push_back(vec_t'{0,1,32'h00000001,0, 1,1,1,32'hdeadbeef, 1,0,0,32'hdeadbeef});
    tbl.push_back(vec_t'{0,1,32'h12345678,0, 2,1,1,32'hdeadbeef, 2,0,0,32'hdeadbeef});
    tbl.push_back(vec_t'{0,0,32'h0,1,        3,1,1,32'hdeadbeef, 3,0,0,32'hdeadbeef});
    tbl.push_back(vec_t'{0,0,32'h0,1,        2,1,1,32'h00000001, 2,0,0,32'h00000001});
    tbl.push_back(vec_t'{0,0,32'h0,1,        1,1,1,32'h12345678, 1,0,0,32'h12345678});
    tbl.push_back(vec_t'{0,0,32'h0,0,        0,1,0,32'h0,        0,0,0,32'h0});
    // Five pushes into a 4-deep FIFO: blocking stalls, non-blocking drops.
    tbl.push_back(vec_t'{0,1,32'ha0,0,       0,1,0,32'h0,        0,0,0,32'h0});
    tbl.push_back(vec_t'{0,1,32'ha1,0,       1,1,1,32'ha0,       1,0,0,32'ha0});
    tbl.push_back(vec_t'{0,1,32'ha2,0,       2,1,1,32'ha0,       2,0,0,32'ha0});
    tbl.push_back(vec_t'{0,1,32'ha3,0,       3,1,1,32'ha0,       3,0,0,32'ha0});
    tbl.push_back(vec_t'{0,1,32'ha4,0,       4,0,1,32'ha0,       4,1,0,32'ha0});
    tbl.push_back(vec_t'{0,1,32'ha4,1,       4,0,1,32'ha0,       4,0,0,32'ha0});
    tbl.push_back(vec_t'{0,1,32'ha4,0,       3,1,1,32'ha1,       4,1,0,32'ha1});
    tbl.push_back(vec_t'{0,0,32'h0,1,        4,0,1,32'ha1,       4,0,0,32'ha1});
    tbl.push_back(vec_t'{0,0,32'h0,1,        3,1,1,32'ha2,       3,0,0,32'ha2});
    tbl.push_back(vec_t'{0,0,32'h0,1,        2,1,1,32'ha3,       2,0,0,32'ha3});
    tbl.push_back(vec_t'{0,0,32'h0,1,        1,1,1,32'ha4,       1,0,0,32'ha4});
    tbl.push_back(vec_t'{0,0,32'h0,1,        0,1,0,32'h0,        0,0,1,32'h0});
    tbl.push_back(vec_t'{0,0,32'h0,0,        0,1,0,32'h0,        0,0,0,32'h0});
    // Reset with a simultaneous push and pop discards everything.
    tbl.push_back(vec_t'{0,1,32'hb0,0,       0,1,0,32'h0,        0,0,0,32'h0});
    tbl.push_back(vec_t'{0,1,32'hb1,0,       1,1,1,32'hb0,       1,0,0,32'hb0});
    tbl.push_back(vec_t'{0,1,32'hb2,0,       2,1,1,32'hb0,       2,0,0,32'hb0});
    tbl.push_back(vec_t'{1,1,32'hb3,1,       3,1,1,32'hb0,       3,0,0,32'hb0});
    tbl.push_back(vec_t'{0,1,32'hc0,0,       0,1,0,32'h0,        0,0,0,32'h0});
    tbl.push_back(vec_t'{0,0,32'h0,1,        1,1,1,32'hc0,       1,0,0,32'hc0});
    tbl.push_back(vec_t'{0,0,32'h0,0,        0,1,0,32'h0,        0,0,0,32'h0});

    rst = 1'b1; wv = 1'b0; wd = '0; rr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("reset_blk_level", 32'(lvl0), 32'd0);
    chk("reset_blk_rvalid", 32'(rv0), 32'd0);
    chk("reset_nb_level", 32'(lvl1), 32'd0);

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].w, tbl[i].d, tbl[i].rd_rdy);
      chk("tbl_blk_level", 32'(lvl0), 32'(tbl[i].l0));
      chk("tbl_blk_wready", 32'(wr0), 32'(tbl[i].wr0));
      chk("tbl_blk_rvalid", 32'(rv0), 32'(tbl[i].rv0));
      if (tbl[i].rv0) chk("tbl_blk_rdata", rd0, tbl[i].rd0);
      chk("tbl_nb_level", 32'(lvl1), 32'(tbl[i].l1));
      chk("tbl_nb_rdata", rd1, tbl[i].rd1);
      if (!tbl[i].r) begin
        chk("tbl_nb_werror", 32'(werr1), 32'(tbl[i].we1));
        chk("tbl_nb_rerror", 32'(rerr1), 32'(tbl[i].re1));
      end
      advance();
    end

    // Full FIFO with push+pop every cycle: pointers wrap, level pinned at DEPTH (non-blocking).
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 32'hf0 + 32'(i), 1'b0);
      advance();
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 32'h10 + 32'(i), 1'b1);
      chk("full_pp_level", 32'(lvl1), 32'd4);
      chk("full_pp_werror", 32'(werr1), 32'd0);
      chk("full_pp_rdata", rd1, (i < 4) ? 32'hf0 + 32'(i) : 32'h10 + 32'(i - 4));
      advance();
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      if (i < 4) chk("full_pp_drain", rd1, 32'h14 + 32'(i));
      advance();
    end

    // Bridge-style traffic: two writes, two reads, then an underflowing read (error response).
    drive(1'b0, 1'b1, 32'hdeadbeef, 1'b0);
    chk("bus_wr1_err", 32'(werr1), 32'd0);
    advance();
    drive(1'b0, 1'b1, 32'hcafef00d, 1'b0);
    chk("bus_wr2_err", 32'(werr1), 32'd0);
    advance();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("bus_rd1_data", rd1, 32'hdeadbeef);
    chk("bus_rd1_err", 32'(rerr1), 32'd0);
    advance();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("bus_rd2_data", rd1, 32'hcafef00d);
    chk("bus_rd2_err", 32'(rerr1), 32'd0);
    advance();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("bus_rd3_err", 32'(rerr1), 32'd1);
    chk("bus_rd3_data", rd1, 32'd0);
    advance();

    // Random traffic, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 55),
            $urandom(), ($urandom_range(0, 99) < 50));
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
